// File: rtl/redmule_w_buffer_ctrl_if.sv
// Handshake and address bundle between the W-buffer sequencer and its
// surroundings: the W streamer (valid/ready, write strobe/row), the buffer
// storage (clear, read addresses) and the engine row-feed (read ready,
// read strobe, rdata valid).
//   master : the sequencer (drives strobes, addresses, w_ready, rd_valid)
//   slave  : streamer/buffer/engine side (drives w_valid, rd_ready)
interface redmule_w_buffer_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int ELMS = 2
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int EW = (ELMS > 1) ? $clog2(ELMS) : 1;

    logic                     w_valid;
    logic                     w_ready;
    logic                     write_en;
    logic [RW-1:0]            write_addr;
    logic                     clear;
    logic                     rd_ready;
    logic                     read_en;
    logic [EW-1:0]            elms_read_addr;
    logic [CW-1:0]            cols_read_offs;
    logic [ROWS-1:0][RW-1:0]  rows_read_addr;
    logic                     rd_valid;

    modport master (
        input  w_valid, rd_ready,
        output w_ready, write_en, write_addr, clear,
               read_en, elms_read_addr, cols_read_offs, rows_read_addr, rd_valid
    );

    modport slave (
        output w_valid, rd_ready,
        input  w_ready, write_en, write_addr, clear,
               read_en, elms_read_addr, cols_read_offs, rows_read_addr, rd_valid
    );
endinterface

// File: rtl/redmule_w_buffer_ctrl.sv
// Sequencer for the RedMulE W-operand buffer. A tile is: clear the buffer,
// load ROWS row-words from the W streamer, wait one cycle for the last latch
// row to commit, then replay the tile reps times (element index innermost,
// then column offset, then pass) toward the engine.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   clear_i  synchronous abort (reset effect plus clear pulse on wbuf.clear)
//   start_i  start a tile, sampled only when idle
//   reps_i   replay count, sampled with start_i (0 behaves as 1)
//   busy_o   high whenever a tile is in progress
//   done_o   one-cycle pulse at tile end
//   wbuf     streamer/buffer/engine handshake and address bundle
module redmule_w_buffer_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ELMS   = 2,
    parameter int REPS_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [REPS_W-1:0] reps_i,
    output logic              busy_o,
    output logic              done_o,
    redmule_w_buffer_ctrl_if.master wbuf
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int EW = (ELMS > 1) ? $clog2(ELMS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        GAP   = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e              state_r;
    logic [REPS_W-1:0]   reps_q_r;
    logic [RW-1:0]       wcnt_r;
    logic [EW-1:0]       ecnt_r;
    logic [CW-1:0]       ccnt_r;
    logic [REPS_W-1:0]   pcnt_r;
    logic                busy_r;
    logic                done_r;
    logic                clr_st_r;
    logic                rd_valid_r;

    logic                w_ready_s;
    logic                write_en_s;
    logic                read_en_s;
    logic                last_wr_s;
    logic                e_wrap_s;
    logic                c_wrap_s;
    logic                last_rd_s;

    // Handshake strobes and wrap/last-beat detection from state and counters.
    always_comb begin
        w_ready_s  = 1'b0;
        read_en_s  = 1'b0;
        if (state_r == LOAD) begin
            w_ready_s = 1'b1;
        end else begin
            w_ready_s = 1'b0;
        end
        if (state_r == READ) begin
            read_en_s = wbuf.rd_ready;
        end else begin
            read_en_s = 1'b0;
        end
        write_en_s = wbuf.w_valid & w_ready_s;
        last_wr_s  = (wcnt_r == RW'(ROWS - 1));
        e_wrap_s   = (ecnt_r == EW'(ELMS - 1));
        c_wrap_s   = (ccnt_r == CW'(COLS - 1));
        last_rd_s  = e_wrap_s & c_wrap_s & (pcnt_r == (reps_q_r - REPS_W'(1)));
    end

    // Sequencer FSM, address counters, status flags and rdata-valid pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_r    <= IDLE;
            reps_q_r   <= REPS_W'(1);
            wcnt_r     <= '0;
            ecnt_r     <= '0;
            ccnt_r     <= '0;
            pcnt_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            clr_st_r   <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= read_en_s;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        reps_q_r <= (reps_i == '0) ? REPS_W'(1) : reps_i;
                        state_r  <= CLEAR;
                        busy_r   <= 1'b1;
                        clr_st_r <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                        clr_st_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    wcnt_r   <= '0;
                    ecnt_r   <= '0;
                    ccnt_r   <= '0;
                    pcnt_r   <= '0;
                    clr_st_r <= 1'b0;
                    state_r  <= LOAD;
                end
                LOAD: begin
                    if (write_en_s) begin
                        wcnt_r <= wcnt_r + RW'(1);
                        if (last_wr_s) begin
                            state_r <= GAP;
                        end
                    end
                end
                // Latch rows land one cycle after write_en; give the last one time.
                GAP: begin
                    state_r <= READ;
                end
                READ: begin
                    if (read_en_s) begin
                        ecnt_r <= ecnt_r + EW'(1);
                        if (e_wrap_s) begin
                            ccnt_r <= ccnt_r + CW'(1);
                            if (c_wrap_s) begin
                                pcnt_r <= pcnt_r + REPS_W'(1);
                            end
                        end
                        if (last_rd_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    clr_st_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o              = busy_r;
    assign done_o              = done_r;
    assign wbuf.w_ready        = w_ready_s;
    assign wbuf.write_en       = write_en_s;
    assign wbuf.write_addr     = wcnt_r;
    // The abort must reach the buffer in the same cycle it is requested.
    assign wbuf.clear          = clear_i | clr_st_r;
    assign wbuf.read_en        = read_en_s;
    assign wbuf.elms_read_addr = ecnt_r;
    assign wbuf.cols_read_offs = ccnt_r;
    assign wbuf.rd_valid       = rd_valid_r;

    // Each buffer row reads its own index; the column skew is applied downstream.
    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign wbuf.rows_read_addr[r] = RW'(r);
    end
endmodule

// File: tb/tb_redmule_w_buffer_ctrl.sv
module tb_redmule_w_buffer_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int ELMS = 2;
    localparam int REPS_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              start = 1'b0;
    logic [REPS_W-1:0] reps = '0;
    logic              busy;
    logic              done;
    logic              tog = 1'b0;

    redmule_w_buffer_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .ELMS(ELMS)) wif ();

    redmule_w_buffer_ctrl #(.ROWS(ROWS), .COLS(COLS), .ELMS(ELMS), .REPS_W(REPS_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr),
        .start_i (start),
        .reps_i  (reps),
        .busy_o  (busy),
        .done_o  (done),
        .wbuf    (wif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int val;} ev_t;
    ev_t wr_q[$], rd_q[$], rv_q[$], dn_q[$], cl_q[$];
    ev_t e;
    int errors = 0;
    int checks = 0;
    int t0 = 0;
    int done_cnt = 0;
    int rel;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - t0);
        end
    endtask

    function automatic ev_t mk(input int c, input int v);
        ev_t x;
        x.cyc = c;
        x.val = v;
        return x;
    endfunction

    // Monitor: pop one expectation per observed DUT event
    always @(negedge clk) begin
        if (!rst) begin
            rel = cyc - t0;
            if (wif.write_en) begin
                if (wr_q.size() == 0) chk("wr_extra_depth", wr_q.size(), 1);
                else begin
                    e = wr_q.pop_front();
                    if (e.cyc >= 0) chk("wr_cycle", rel, e.cyc);
                    chk("wr_addr", int'(wif.write_addr), e.val);
                end
            end
            if (wif.read_en) begin
                if (rd_q.size() == 0) chk("rd_extra_depth", rd_q.size(), 1);
                else begin
                    e = rd_q.pop_front();
                    if (e.cyc >= 0) chk("rd_cycle", rel, e.cyc);
                    chk("rd_col_elm", int'({wif.cols_read_offs, wif.elms_read_addr}), e.val);
                end
            end
            if (wif.rd_valid) begin
                if (rv_q.size() == 0) chk("rv_extra_depth", rv_q.size(), 1);
                else begin
                    e = rv_q.pop_front();
                    if (e.cyc >= 0) chk("rv_cycle", rel, e.cyc);
                end
            end
            if (wif.clear) begin
                if (cl_q.size() == 0) chk("clr_extra_depth", cl_q.size(), 1);
                else begin
                    e = cl_q.pop_front();
                    if (e.cyc >= 0) chk("clr_cycle", rel, e.cyc);
                end
            end
            if (done) begin
                done_cnt++;
                if (dn_q.size() == 0) chk("done_extra_depth", dn_q.size(), 1);
                else begin
                    e = dn_q.pop_front();
                    if (e.cyc >= 0) chk("done_cycle", rel, e.cyc);
                    chk("done_busy", int'(busy), e.val);
                end
            end
        end
    end

    // Full tile expectations; cycles relative to the start_i cycle
    task automatic push_tile(input int np, input bit timed);
        int idx;
        idx = 0;
        cl_q.push_back(mk(timed ? 1 : -1, 1));
        for (int k = 0; k < ROWS; k++) wr_q.push_back(mk(timed ? 2 + k : -1, k));
        for (int p = 0; p < np; p++)
            for (int c = 0; c < COLS; c++)
                for (int el = 0; el < ELMS; el++) begin
                    rd_q.push_back(mk(timed ? 7 + idx : -1, c * ELMS + el));
                    rv_q.push_back(mk(timed ? 8 + idx : -1, 1));
                    idx++;
                end
        dn_q.push_back(mk(timed ? 7 + idx : -1, 1));
    endtask

    task automatic start_tile(input int r);
        @(posedge clk); #1;
        start = 1'b1;
        reps = REPS_W'(r);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit toggle);
        int seen;
        seen = done_cnt;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (toggle) begin
                tog = ~tog;
                wif.w_valid = tog;
                wif.rd_ready = tog;
            end
            if (done_cnt > seen) break;
        end
        chk("done_count", done_cnt - seen, 1);
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
        chk("wr_left", wr_q.size(), 0);
        chk("rd_left", rd_q.size(), 0);
        chk("rv_left", rv_q.size(), 0);
        chk("clr_left", cl_q.size(), 0);
        chk("done_left", dn_q.size(), 0);
    endtask

    initial begin
        wif.w_valid = 1'b1;
        wif.rd_ready = 1'b1;
        // Reset state (handshake inputs high must not produce strobes)
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_ready", int'(wif.w_ready), 0);
        chk("rst_write_en", int'(wif.write_en), 0);
        chk("rst_clear", int'(wif.clear), 0);
        chk("rst_read_en", int'(wif.read_en), 0);
        chk("rst_rd_valid", int'(wif.rd_valid), 0);
        chk("rst_write_addr", int'(wif.write_addr), 0);
        chk("rst_elms", int'(wif.elms_read_addr), 0);
        chk("rst_cols", int'(wif.cols_read_offs), 0);
        chk("rst_rows", int'(wif.rows_read_addr), 32'hE4);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_busy", int'(busy), 0);
        end

        // Nominal tile, reps=2
        push_tile(2, 1'b1);
        start_tile(2);
        wait_done(60, 1'b0);
        drain(3);

        // Handshake stalls every other cycle
        wif.w_valid = 1'b0;
        wif.rd_ready = 1'b0;
        push_tile(2, 1'b0);
        start_tile(2);
        wait_done(200, 1'b1);
        drain(3);

        // reps=0 behaves as one pass
        wif.w_valid = 1'b1;
        wif.rd_ready = 1'b1;
        push_tile(1, 1'b1);
        start_tile(0);
        wait_done(60, 1'b0);
        drain(3);

        // Abort on the 5th read (cycle 11)
        cl_q.push_back(mk(1, 1));
        for (int k = 0; k < ROWS; k++) wr_q.push_back(mk(2 + k, k));
        for (int k = 0; k < 5; k++) rd_q.push_back(mk(7 + k, k));
        for (int k = 0; k < 4; k++) rv_q.push_back(mk(8 + k, 1));
        cl_q.push_back(mk(11, 1));
        start_tile(2);
        repeat (10) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_valid", int'(wif.rd_valid), 0);
        drain(3);
        push_tile(2, 1'b1);
        start_tile(2);
        wait_done(60, 1'b0);
        drain(3);

        // start_i pulses during LOAD and READ are ignored
        push_tile(2, 1'b1);
        start_tile(2);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        reps = REPS_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reps = '0;
        wait_done(60, 1'b0);
        drain(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
